issue_select: RTL
=================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter DEPTH, default 8, which sets the number of queue entries.
REQ-002 SHALL have parameter PAYLOAD_W, default 64, which sets the opaque instruction payload width.
REQ-003 SHALL have parameter MULT_LAT, default 4, which sets the cycles a multiplier is held busy locally after an issue.
REQ-004 SHALL have ports clock (input, 1): the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset (input, 1): asynchronous, active-high; this is already decided.
REQ-006 SHALL have port disp_valid (input, 1): a dispatch write request.
REQ-007 SHALL have port disp_fu_type (input, 2): 0 ALU, 1 MULT, 2 BRANCH, 3 reserved.
REQ-008 SHALL have port disp_payload (input, PAYLOAD_W): the instruction payload, carried unmodified.
REQ-009 SHALL have port disp_ready (output, 1): the queue can accept a write this cycle.
REQ-010 SHALL have port fu_busy (input, 6): unit busy/stall flags from the FU block; bit 0 ALU_1, 1 ALU_2, 2 ALU_3, 3 MULT_1, 4 MULT_2, 5 BRANCH.
REQ-011 SHALL have port fu_stall (input, 1): the FU completion-conflict stall; no issue is allowed while it is high.
REQ-012 SHALL have port issue_valid (output, 1): a registered issue strobe.
REQ-013 SHALL have port issue_fu_select (output, 3): the target unit; 0 ALU_1, 1 ALU_2, 2 ALU_3, 3 MULT_1, 4 MULT_2, 5 BRANCH.
REQ-014 SHALL have port issue_payload (output, PAYLOAD_W): the payload of the issued entry.
REQ-015 SHALL have port occupancy (output, $clog2(DEPTH)+1): the count of valid entries.

Function
REQ-016 SHALL hold entries in an age-ordered compacting queue, with index 0 the oldest.
REQ-017 SHALL compute disp_ready = (occupancy < DEPTH) from registered state only, with no same-cycle bypass of an issue.
REQ-018 SHALL write the entry at the tail when disp_valid & disp_ready; disp_valid while !disp_ready SHALL be ignored with no state change.
REQ-019 SHALL drop disp_fu_type==3 (no entry written) and SHALL NOT change occupancy for it.
REQ-020 SHALL treat unit u as free iff !fu_busy[u], its local hold is 0 (MULT units only), and it was not the unit issued to in the previous cycle.
REQ-021 SHALL select each cycle, when fu_stall==0, the oldest valid entry whose type has at least one free unit; within a type the lowest-numbered free unit SHALL win.
REQ-022 SHALL issue at most one entry per cycle.
REQ-023 SHALL register the selection: issue_valid, issue_fu_select and issue_payload appear on the cycle after selection and persist exactly one cycle.
REQ-024 SHALL set issue_valid=0 with issue_fu_select and issue_payload driven to 0 when nothing is selected.
REQ-025 SHALL remove the selected entry in the same edge that registers the issue, shifting younger entries down by one.
REQ-026 SHALL, on a simultaneous write and issue, place the new entry at the post-shift tail; occupancy is then unchanged.
REQ-027 SHALL load the issued MULT unit's hold counter with MULT_LAT-1 and decrement it by 1 per cycle, saturating at 0.
REQ-028 SHALL keep counters decrementing while fu_stall is high.
REQ-029 SHALL use a younger entry of another type when the oldest entry's type has no free unit (no head-of-line blocking across types).
REQ-030 SHALL, when fu_stall is high, make no selection, remove no entry, and still accept dispatch writes.

Reset
REQ-031 SHALL, on reset assertion, immediately clear all entries, occupancy, hold counters, the previous-issue record, issue_valid, issue_fu_select and issue_payload, with disp_ready becoming 1.
REQ-032 SHALL, on reset assertion mid-operation, discard pending entries with no issue output.
REQ-033 SHALL produce no issue on the first edge after reset release.

Verification
REQ-034 SHALL verify: dispatch ALU with payload 0xA at cycle 0, fu_busy=0 -> issue_valid=1, issue_fu_select=0, issue_payload=0xA at cycle 2; occupancy back to 0.
REQ-035 SHALL verify: fill 8 entries -> disp_ready=0; a ninth disp_valid is dropped; one issue -> disp_ready=1 the next cycle and occupancy=7.
REQ-036 SHALL verify: two MULTs back-to-back with MULT_LAT=4 -> MULT_1 then MULT_2; a third MULT waits until MULT_1's hold reaches 0 and is issued 4 cycles after the first MULT issue.
REQ-037 SHALL verify: queue holds [MULT, ALU] with fu_busy[4:3]=2'b11 -> the ALU issues first to ALU_1 and the MULT remains at index 0.
REQ-038 SHALL verify: fu_stall=1 for 3 cycles with 2 ALU entries -> no issue_valid and occupancy=2 throughout; issues resume the cycle after fu_stall falls.
REQ-039 SHALL verify: reset asserted with occupancy=5 and issue_valid=1 -> outputs 0 and occupancy 0 immediately, and no issue on the first edge after release.

Source files
------------

// File: rtl/issue_select.sv
// Age-ordered issue queue: picks the oldest entry whose FU type has a free unit,
// registers the issue, and compacts the queue in the same edge.
module issue_select #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 64,
  parameter int MULT_LAT  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   disp_valid,
  input  logic [1:0]             disp_fu_type,
  input  logic [PAYLOAD_W-1:0]   disp_payload,
  output logic                   disp_ready,
  input  logic [5:0]             fu_busy,
  input  logic                   fu_stall,
  output logic                   issue_valid,
  output logic [2:0]             issue_fu_select,
  output logic [PAYLOAD_W-1:0]   issue_payload,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = IDX_W + 1;
  localparam int HOLD_W = $clog2(MULT_LAT) + 1;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_BRANCH = 2'd2,
    FU_RSVD   = 2'd3
  } fu_type_e;

  fu_type_e               r_type    [DEPTH];
  logic [PAYLOAD_W-1:0]   r_payload [DEPTH];
  logic [CNT_W-1:0]       r_count;
  logic [HOLD_W-1:0]      r_hold    [2];
  logic                   r_issue_valid;
  logic [2:0]             r_issue_sel;
  logic [PAYLOAD_W-1:0]   r_issue_payload;

  logic [5:0]             w_free;
  logic                   w_type_ok   [4];
  logic [2:0]             w_type_unit [4];
  logic                   w_sel_valid;
  logic [IDX_W-1:0]       w_sel_idx;
  logic [2:0]             w_sel_unit;
  logic                   w_wr;
  logic [IDX_W-1:0]       w_wr_idx;

  // A unit is unavailable if flagged busy, still in its MULT hold, or issued to last cycle.
  always_comb begin
    for (int u = 0; u < 6; u++) begin
      w_free[u] = !fu_busy[u] && !(r_issue_valid && (r_issue_sel == 3'(u)));
    end
    w_free[3] = w_free[3] && (r_hold[0] == '0);
    w_free[4] = w_free[4] && (r_hold[1] == '0);
  end

  always_comb begin
    w_type_ok[FU_ALU]      = |w_free[2:0];
    w_type_unit[FU_ALU]    = w_free[0] ? 3'd0 : (w_free[1] ? 3'd1 : 3'd2);
    w_type_ok[FU_MULT]     = |w_free[4:3];
    w_type_unit[FU_MULT]   = w_free[3] ? 3'd3 : 3'd4;
    w_type_ok[FU_BRANCH]   = w_free[5];
    w_type_unit[FU_BRANCH] = 3'd5;
    w_type_ok[FU_RSVD]     = 1'b0;
    w_type_unit[FU_RSVD]   = 3'd0;
  end

  // NOTE: scanning youngest to oldest lets the last match (the oldest) win without a found flag.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_sel_unit  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!fu_stall && (CNT_W'(i) < r_count) && w_type_ok[r_type[i]]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_unit  = w_type_unit[r_type[i]];
      end
    end
  end

  assign disp_ready = (r_count < CNT_W'(DEPTH));
  assign w_wr       = disp_valid && disp_ready && (disp_fu_type != FU_RSVD);
  assign w_wr_idx   = IDX_W'(w_sel_valid ? (r_count - CNT_W'(1)) : r_count);

  // NOTE: the entry array is reset too, so no stale payload survives a mid-run reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i]    <= FU_ALU;
        r_payload[i] <= '0;
      end
      r_count         <= '0;
      r_hold[0]       <= '0;
      r_hold[1]       <= '0;
      r_issue_valid   <= 1'b0;
      r_issue_sel     <= '0;
      r_issue_payload <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (w_sel_valid && (IDX_W'(i) >= w_sel_idx)) begin
          r_type[i]    <= r_type[i+1];
          r_payload[i] <= r_payload[i+1];
        end
      end
      // NOTE: this write follows the shift so it overrides it at the post-shift tail.
      if (w_wr) begin
        r_type[w_wr_idx]    <= fu_type_e'(disp_fu_type);
        r_payload[w_wr_idx] <= disp_payload;
      end
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_sel_valid);
      for (int m = 0; m < 2; m++) begin
        if (w_sel_valid && (w_sel_unit == 3'(3 + m))) begin
          r_hold[m] <= HOLD_W'(MULT_LAT - 1);
        end else if (r_hold[m] != '0) begin
          r_hold[m] <= r_hold[m] - HOLD_W'(1);
        end
      end
      r_issue_valid   <= w_sel_valid;
      r_issue_sel     <= w_sel_valid ? w_sel_unit : 3'd0;
      r_issue_payload <= w_sel_valid ? r_payload[w_sel_idx] : '0;
    end
  end

  assign issue_valid     = r_issue_valid;
  assign issue_fu_select = r_issue_sel;
  assign issue_payload   = r_issue_payload;
  assign occupancy       = r_count;

endmodule
